// File: rtl/sbox_pkg.sv
// Shared types and helpers for the runtime-loadable S-box lookup engine.
// Holds the FSM state encoding, default widths and the identity-fill value.
package sbox_pkg;

    localparam int DEF_IN_W  = 4;
    localparam int DEF_OUT_W = 4;
    localparam int DEF_LANES = 1;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Identity entry for index cnt: keeps only the low out_w bits, so callers
    // get truncation when out_w < in_w and zero-extension otherwise.
    function automatic logic [31:0] ident_val(input logic [31:0] cnt, input int out_w);
        logic [31:0] mask;
        mask = (out_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << out_w) - 32'd1);
        return cnt & mask;
    endfunction

endpackage

// File: rtl/sbox_table_ram.sv
// Shared S-box table: one synchronous write port, LANES combinational read ports.
// Reads see the pre-edge contents, so a same-cycle write never leaks into a captured read.
module sbox_table_ram
    import sbox_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W,
    parameter int LANES = DEF_LANES
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [IN_W-1:0]        waddr,
    input  logic [OUT_W-1:0]       wdata,
    input  logic [LANES*IN_W-1:0]  raddr,
    output logic [LANES*OUT_W-1:0] rdata
);

    localparam int DEPTH = 2 ** IN_W;

    logic [OUT_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_rd
        assign rdata[k*OUT_W +: OUT_W] = mem[raddr[k*IN_W +: IN_W]];
    end

endmodule

// File: rtl/sbox_lut_pipe.sv
// Multi-lane S-box lookup with a hardware identity sweep after reset, a config
// write port, and a single registered output stage behind a valid/ready handshake.
module sbox_lut_pipe
    import sbox_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W,
    parameter int LANES = DEF_LANES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*IN_W-1:0]  in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*OUT_W-1:0] out_data,
    input  logic                   cfg_we,
    input  logic [IN_W-1:0]        cfg_addr,
    input  logic [OUT_W-1:0]       cfg_data,
    output logic                   cfg_ready,
    output logic                   busy,
    output state_t                 state
);

    // Handshake: a beat transfers on any edge where valid && ready are both high;
    // the source holds data stable while valid is high and ready is low.

    state_t                  state_q, state_d;
    logic [IN_W-1:0]         cnt_q;
    logic                    run;
    logic                    accept;
    logic                    wr_en;
    logic [IN_W-1:0]         wr_addr;
    logic [OUT_W-1:0]        wr_data;
    logic [LANES*OUT_W-1:0]  rd_data;
    logic                    out_valid_q;
    logic [LANES*OUT_W-1:0]  out_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == INIT) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == INIT && cnt_q == {IN_W{1'b1}}) begin
            state_d = RUN;
        end
    end

    assign run       = (state_q == RUN) && !rst;
    assign cfg_ready = run;
    assign busy      = !run;
    assign state     = state_q;
    assign in_ready  = run && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;

    // The sweep owns the write port during INIT; config writes are dropped there.
    assign wr_en   = !rst && ((state_q == INIT) || cfg_we);
    assign wr_addr = (state_q == INIT) ? cnt_q : cfg_addr;
    assign wr_data = (state_q == INIT) ? OUT_W'(ident_val(32'(cnt_q), OUT_W)) : cfg_data;

    sbox_table_ram #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .LANES (LANES)
    ) u_table (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (in_data),
        .rdata (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= rd_data;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: doc/sbox_lut_pipe.md
Name: sbox_lut_pipe

Overview:
- Parametrised, runtime-loadable S-box lookup engine; next generation of the fixed 4-bit identity S-box.
- Generalised input/output width and lane count; one shared table serves all lanes.
- After reset, the table is initialised to identity by a hardware sweep, then rewritten through a config port.
- Lookups use a valid/ready handshake with one registered output stage; sits between the miner datapath stages.

Parameters:
- IN_W, 4, lookup index width; table depth = 2**IN_W.
- OUT_W, 4, table entry width.
- LANES, 1, parallel lookups per beat, all reading the same table.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  lookup beat offered.
- in_ready  output  1  lookup beat accepted when in_valid && in_ready.
- in_data  input  LANES*IN_W  lane k index at bits [k*IN_W +: IN_W].
- out_valid  output  1  result beat held.
- out_ready  input  1  downstream accepts the result.
- out_data  output  LANES*OUT_W  lane k result at [k*OUT_W +: OUT_W].
- cfg_we  input  1  table write strobe.
- cfg_addr  input  IN_W  table write address.
- cfg_data  input  OUT_W  table write data.
- cfg_ready  output  1  high when table writes are honoured.
- busy  output  1  high during the init sweep.

Behaviour:
- Reset: clk and rst only (synchronous, active-high). While rst=1: out_valid=0, out_data=0, in_ready=0, cfg_ready=0, busy=1, init counter=0, state=INIT.
- Reset mid-operation: any held result is dropped (out_valid=0 next cycle), table contents are discarded, and the init sweep restarts.
- States:
  - INIT: writes entry[cnt] = cnt, truncated to OUT_W if OUT_W<IN_W, zero-extended otherwise; cnt increments each cycle. After the write of entry 2**IN_W-1, moves to RUN. The sweep takes exactly 2**IN_W cycles after rst falls.
  - RUN: busy=0, cfg_ready=1. No exit except rst.
- In INIT: in_ready=0, and cfg_we is ignored (no effect, not queued).
- Handshake (RUN only): in_ready = !out_valid || out_ready.
- On acceptance: out_data lanes = table[lane index], registered; out_valid=1 the next cycle. Latency is 1 cycle.
- Output stall: out_valid && !out_ready holds out_data and out_valid stable; in_ready=0.
- Simultaneous output pop and input accept: the new result replaces the old one with no bubble. Full throughput is 1 beat/cycle.
- out_valid falls only when out_ready=1 and no new beat is accepted.
- Table write in RUN: cfg_we=1 writes table[cfg_addr] at the clock edge.
- Write/read ordering:
  - A lookup accepted in the same cycle as a write to the same address returns the OLD entry.
  - Lookups accepted in later cycles return the new entry.
  - Results already held in the output register are never altered by writes.
- Multiple lanes with the same index in one beat return identical values.
- cfg_addr is always in range (full IN_W decode); there is no error condition.
- No X propagation: out_data is always driven from the reset value or a registered table read.

Decomposition:
- Shared package sbox_pkg:
  - state enum {INIT, RUN}.
  - Function for the identity init value (cnt truncated/zero-extended to OUT_W).
  - Default width constants.
- One natural sub-module: sbox_table_ram, a single write port plus LANES combinational read ports with old-data-on-collision semantics.
- The handshake/output register and the init FSM stay in the top module.

Test Plan:
- Default params: rst high 2 cycles, then low -> busy=1 for exactly 16 cycles, in_ready=0 throughout; then cfg_ready=1; lookup in_data=4'h9 -> out_data=4'h9 one cycle after accept.
- Write addr 3 -> 4'hC, then lookup 3 the next cycle -> 4'hC. Write addr 5 -> 4'h1 in the same cycle a lookup of 5 is accepted -> out_data=4'h5 (old value); lookup 5 the following cycle -> 4'h1.
- LANES=4, IN_W=8, OUT_W=8: after init, write table[0x2A]=0xE7 -> in_data {0x2A,0x00,0x2A,0xFF} returns {0xE7,0x00,0xE7,0xFF} one cycle after accept.
- Backpressure: stream indices 0..7 with out_ready toggling 1,0,0,1 -> no loss or duplication; out_data stable while stalled; 8 beats in 8 cycles when out_ready is held at 1.
- Reset mid-stream: out_valid=1 with an entry previously rewritten, assert rst 1 cycle -> out_valid=0, busy=1 for 2**IN_W cycles; that entry reads back as identity afterwards.
- cfg_we pulsed during INIT (addr 2, data 4'hF) -> ignored; lookup 2 after init returns 4'h2.
